// File: rtl/mem_pkg.sv
// Shared definitions for the load/store data memory: funct3 encodings,
// controller FSM states and the access-size helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_e;

  // Bytes touched by an access; 0 for the reserved size encoding.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/ack bus between the core's LSU (master) and the data memory (slave).
interface data_mem_ctrl_if;
  logic        i_stb;
  logic        i_wr_en;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_write_data;
  logic        o_busy;
  logic        o_ack;
  logic [31:0] o_read_data;
  logic        o_err;

  modport master (
    output i_stb, i_wr_en, i_funct3, i_addr, i_write_data,
    input  o_busy, o_ack, o_read_data, o_err
  );

  modport slave (
    input  i_stb, i_wr_en, i_funct3, i_addr, i_write_data,
    output o_busy, o_ack, o_read_data, o_err
  );
endinterface

// File: rtl/load_align.sv
// Picks a byte/halfword out of a 32-bit word by byte offset and extends it.
// Purely combinational.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      F3_W:    data = word;
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with RV32I sub-word access and fault detection.
// Ack arrives WAIT_STATES+1 cycles after accept; strobes are ignored while busy.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  bus
);

  localparam int IW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        rsp_load;

  logic [7:0]  mem [DEPTH_BYTES];

  // In IDLE the live inputs describe the access being accepted; later the captured copy does.
  logic        req_wr;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] offset;
  logic [2:0]  nbytes;
  logic [1:0]  align_mask;
  logic        illegal, misaligned, out_of_range, fault;
  logic [IW-1:0] word_base;
  logic [3:0]  be;
  logic [31:0] wr_lane;
  logic [31:0] rd_word;
  logic [31:0] aligned;

  assign req_wr   = (state_q == MEM_IDLE) ? bus.i_wr_en  : wr_q;
  assign req_f3   = (state_q == MEM_IDLE) ? bus.i_funct3 : f3_q;
  assign req_addr = (state_q == MEM_IDLE) ? bus.i_addr   : addr_q;
  assign offset   = req_addr - BASE_ADDR;

  assign nbytes       = access_bytes(req_f3);
  assign align_mask   = 2'(nbytes - 3'd1);
  assign misaligned   = (offset[1:0] & align_mask) != 2'd0;
  assign out_of_range = offset >= 32'(DEPTH_BYTES);
  assign illegal      = req_wr ? (req_f3 > F3_W)
                               : (req_f3 == 3'b011 || req_f3 == 3'b110 || req_f3 == 3'b111);
  assign fault        = illegal || misaligned || out_of_range;

  assign word_base = {offset[IW-1:2], 2'b00};
  assign be = (nbytes == 3'd4) ? 4'hF
            : (nbytes == 3'd2) ? (4'b0011 << offset[1:0])
            :                    (4'b0001 << offset[1:0]);
  assign wr_lane = bus.i_write_data << {offset[1:0], 3'b000};
  assign rd_word = {mem[word_base + IW'(3)], mem[word_base + IW'(2)],
                    mem[word_base + IW'(1)], mem[word_base]};

  load_align u_align (
    .word   (rd_word),
    .off    (offset[1:0]),
    .funct3 (req_f3),
    .data   (aligned)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    rsp_load = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (bus.i_stb) begin
          accept = 1'b1;
          cnt_d  = WS_LOAD;
          if (WAIT_STATES == 0) begin
            state_d  = MEM_RESP;
            rsp_load = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = MEM_RESP;
          rsp_load = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_RESP: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q   <= bus.i_wr_en;
        f3_q   <= bus.i_funct3;
        addr_q <= bus.i_addr;
      end
      err_q   <= rsp_load && fault;
      rdata_q <= (rsp_load && !fault && !req_wr) ? aligned : 32'd0;
    end
  end

  // Stores commit on the accept edge, so a later load always sees them.
  always_ff @(posedge clk) begin
    if (accept && req_wr && !fault) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[word_base + IW'(k)] <= wr_lane[8*k +: 8];
      end
    end
  end

  assign bus.o_busy      = (state_q != MEM_IDLE);
  assign bus.o_ack       = (state_q == MEM_RESP);
  assign bus.o_read_data = rdata_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (0 and 3 wait states) checked every cycle
// against a byte-array reference model, plus literal expectations from hand calculation.
module tb_data_mem_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_ctrl_if if0 ();
  data_mem_ctrl_if if1 ();

  data_mem_ctrl #(.DEPTH_BYTES(4096), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave));
  data_mem_ctrl #(.DEPTH_BYTES(4096), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
    .clk (clk), .rst (rst), .bus (if1.slave));

  localparam int WSV[2] = '{0, 3};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state per instance
  logic [7:0]  mm [2][4096];
  int          acc_cyc [2] = '{-1, -1};
  int          ack_cyc [2] = '{-1, -1};
  logic [31:0] exp_data [2];
  logic        exp_err  [2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, exp);
    end
  endtask

  task automatic outs(input int d, output logic b, output logic a, output logic e,
                      output logic [31:0] dv);
    if (d == 0) begin
      b = if0.o_busy; a = if0.o_ack; e = if0.o_err; dv = if0.o_read_data;
    end else begin
      b = if1.o_busy; a = if1.o_ack; e = if1.o_err; dv = if1.o_read_data;
    end
  endtask

  task automatic set_stb(input int d, input logic v);
    if (d == 0) if0.i_stb = v; else if1.i_stb = v;
  endtask

  task automatic drive(input int d, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      if0.i_stb = 1'b1; if0.i_wr_en = wr; if0.i_funct3 = f3; if0.i_addr = a; if0.i_write_data = wd;
    end else begin
      if1.i_stb = 1'b1; if1.i_wr_en = wr; if1.i_funct3 = f3; if1.i_addr = a; if1.i_write_data = wd;
    end
  endtask

  // Architectural meaning of one access on a 4 KiB little-endian byte array.
  task automatic m_access(input int d, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic err, output logic [31:0] data);
    int   n;
    logic legal;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    data = 32'd0;
    if (!legal) err = 1'b1;
    else        err = (a >= 32'd4096) || ((a % n) != 0);
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < n; i++) mm[d][a + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) data[8*i +: 8] = mm[d][a + i];
        if (!f3[2] && n < 4 && data[8*n - 1])
          for (int i = n; i < 4; i++) data[8*i +: 8] = 8'hFF;
      end
    end
  endtask

  // Called at a negedge with the instance idle: the next posedge accepts.
  task automatic issue(input int d, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    logic        e;
    logic [31:0] dv;
    drive(d, wr, f3, a, wd);
    acc_cyc[d] = cyc + 1;
    ack_cyc[d] = cyc + 1 + WSV[d];
    m_access(d, wr, f3, a, wd, e, dv);
    exp_err[d]  = e;
    exp_data[d] = dv;
  endtask

  task automatic wait_done(input int d, input bit pulse, output logic [31:0] data,
                           output logic err, output int lat, output int bcnt);
    logic b, a, e;
    logic [31:0] dv;
    bit got;
    got = 0; lat = 0; bcnt = 0; data = 32'd0; err = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      set_stb(d, pulse && (k == 2 || k == 3));
      outs(d, b, a, e, dv);
      if (b) bcnt++;
      if (a) begin
        got = 1; lat = k; data = dv; err = e;
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL ack_timeout inst %0d: got no ack, expected one within 40 cycles", d);
    end
    @(negedge clk);
  endtask

  task automatic xfer(input int d, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] data, output logic err);
    int lat, bcnt;
    issue(d, wr, f3, a, wd);
    wait_done(d, 1'b0, data, err, lat, bcnt);
  endtask

  // Cycle-by-cycle comparison against the model's timing and response
  logic        cp_b, cp_a, cp_e, cp_eb, cp_ea;
  logic [31:0] cp_d;
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        outs(d, cp_b, cp_a, cp_e, cp_d);
        cp_eb = (ack_cyc[d] >= 0) && (cyc >= acc_cyc[d]) && (cyc <= ack_cyc[d]);
        cp_ea = (cyc == ack_cyc[d]);
        chk($sformatf("busy%0d", d), cp_b, cp_eb);
        chk($sformatf("ack%0d", d), cp_a, cp_ea);
        if (cp_ea) begin
          chk($sformatf("err%0d", d), cp_e, exp_err[d]);
          chk($sformatf("rdata%0d", d), cp_d, exp_data[d]);
        end else begin
          chk($sformatf("rdata_idle%0d", d), cp_d, 32'd0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        re;
    int          lat, bcnt, r;
    logic [31:0] a;
    logic        b0, a0, e0;
    logic [31:0] d0;

    if0.i_stb = 0; if0.i_wr_en = 0; if0.i_funct3 = 0; if0.i_addr = 0; if0.i_write_data = 0;
    if1.i_stb = 0; if1.i_wr_en = 0; if1.i_funct3 = 0; if1.i_addr = 0; if1.i_write_data = 0;

    #12;
    for (int d = 0; d < 2; d++) begin
      outs(d, b0, a0, e0, d0);
      chk("reset_busy", b0, 0); chk("reset_ack", a0, 0);
      chk("reset_err", e0, 0);  chk("reset_rdata", d0, 0);
    end
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);

    // Zero wait states: directed sequence
    issue(0, 1, F3_W, 32'h10, 32'hDEADBEEF);
    wait_done(0, 0, rd, re, lat, bcnt);
    chk("sw_lat", lat, 1); chk("sw_err", re, 0);
    issue(0, 0, F3_W, 32'h10, 0);
    wait_done(0, 0, rd, re, lat, bcnt);
    chk("lw_lat", lat, 1); chk("lw_err", re, 0); chk("lw_data", rd, 32'hDEADBEEF);
    xfer(0, 0, F3_B,  32'h10, 0, rd, re); chk("lb",  rd, 32'hFFFFFFEF);
    xfer(0, 0, F3_BU, 32'h13, 0, rd, re); chk("lbu", rd, 32'h000000DE);
    xfer(0, 0, F3_H,  32'h12, 0, rd, re); chk("lh",  rd, 32'hFFFFDEAD);
    xfer(0, 0, F3_HU, 32'h10, 0, rd, re); chk("lhu", rd, 32'h0000BEEF);
    xfer(0, 1, F3_B,  32'h11, 32'h55, rd, re);
    xfer(0, 0, F3_W,  32'h10, 0, rd, re); chk("sb_then_lw", rd, 32'hDEAD55EF);
    xfer(0, 1, F3_H,  32'h12, 32'h1234, rd, re);
    xfer(0, 0, F3_W,  32'h10, 0, rd, re); chk("sh_then_lw", rd, 32'h123455EF);

    // Faults
    xfer(0, 0, F3_W, 32'h12, 0, rd, re);
    chk("lw_misal_err", re, 1); chk("lw_misal_data", rd, 0);
    xfer(0, 1, F3_H, 32'h13, 32'hFFFF, rd, re); chk("sh_misal_err", re, 1);
    xfer(0, 0, F3_W, 32'h10, 0, rd, re); chk("after_fault_lw", rd, 32'h123455EF);
    xfer(0, 0, F3_W, 32'd4096, 0, rd, re); chk("range_err", re, 1);
    xfer(0, 0, 3'b011, 32'h10, 0, rd, re); chk("illegal_f3_err", re, 1);
    xfer(0, 0, F3_W, 32'd4092, 0, rd, re); chk("top_word_ok", re, 0);

    // Three wait states: strobes during busy are ignored
    xfer(1, 1, F3_W, 32'h20, 32'hCAFEF00D, rd, re);
    issue(1, 0, F3_W, 32'h20, 0);
    wait_done(1, 1, rd, re, lat, bcnt);
    chk("ws3_lat", lat, 4); chk("ws3_busy_cycles", bcnt, 4); chk("ws3_data", rd, 32'hCAFEF00D);
    repeat (6) @(negedge clk);

    // Reset two cycles after accept
    issue(1, 0, F3_W, 32'h20, 0);
    @(negedge clk); set_stb(1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    ack_cyc[1] = -1;
    #1;
    outs(1, b0, a0, e0, d0);
    chk("midrst_busy", b0, 0); chk("midrst_ack", a0, 0);
    chk("midrst_err", e0, 0);  chk("midrst_rdata", d0, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    issue(1, 0, F3_W, 32'h20, 0);
    wait_done(1, 0, rd, re, lat, bcnt);
    chk("post_rst_lat", lat, 4); chk("post_rst_data", rd, 32'hCAFEF00D);

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) xfer(d, 1, F3_W, 32'(w * 4), $urandom, rd, re);
      for (int n = 0; n < 120; n++) begin
        r = $urandom_range(0, 15);
        if (r == 0)      a = 32'(4096 + $urandom_range(0, 8));
        else if (r == 1) a = 32'hFFFF_FFF0;
        else             a = 32'($urandom_range(0, 63));
        xfer(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, re);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
